// File: rtl/aula_pio_pkg.sv
// Shared register map and STATUS field positions for the LED output PIO.
package aula_pio_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd1;
  localparam logic [2:0] ADDR_PULSE     = 3'd2;
  localparam logic [2:0] ADDR_STATUS    = 3'd3;
  localparam logic [2:0] ADDR_OUTSET    = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;

  localparam int unsigned STATUS_BUSY_BIT  = 0;
  localparam int unsigned STATUS_COUNT_LSB = 16;

endpackage

// File: rtl/aula_pio_pulse_timer.sv
// Pulse timer: holds the pulse mask while a down-counter runs; a load wins over expiry.
module aula_pio_pulse_timer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_mask,
  input  logic [CNT_W-1:0] len,
  output logic [WIDTH-1:0] mask,
  output logic             busy,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mask_q, mask_d;

  always_comb begin
    count_d = count_q;
    mask_d  = mask_q;
    if (load) begin
      count_d = len;
      mask_d  = load_mask;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
      // Clear on the final tick so the mask is high exactly len cycles.
      if (count_q == CNT_W'(1)) mask_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      mask_q  <= '0;
    end else begin
      count_q <= count_d;
      mask_q  <= mask_d;
    end
  end

  assign mask  = mask_q;
  assign busy  = (count_q != '0);
  assign count = count_q;

endmodule

// File: rtl/aula_20201105_qsys_led_oc.sv
// Avalon-MM LED/strobe output PIO with level register and timed pulses.
// Optional OUTSET/OUTCLEAR registers are built when LED_OC_BITSETCLR_EN is defined.
module aula_20201105_qsys_led_oc
  import aula_pio_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      CNT_W     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

`ifdef LED_OC_BITSETCLR_EN
  localparam bit SetClrEn = 1'b1;
`else
  localparam bit SetClrEn = 1'b0;
`endif

  logic             wr;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             pulse_load;
  logic [WIDTH-1:0] mask;
  logic             busy;
  logic [CNT_W-1:0] count;
  logic             unused_wd;

  assign wr        = chipselect & ~write_n;
  assign unused_wd = ^writedata;

  // Zero-length or empty pulse requests are dropped entirely.
  assign pulse_load = wr && (address == ADDR_PULSE) && (writedata[WIDTH-1:0] != '0) &&
                      (len_q != '0);

  always_comb begin
    data_d = data_q;
    len_d  = len_q;
    if (wr) begin
      case (address)
        ADDR_DATA:      data_d = writedata[WIDTH-1:0];
        ADDR_PULSE_LEN: len_d  = writedata[CNT_W-1:0];
        ADDR_OUTSET:    if (SetClrEn) data_d = data_q | writedata[WIDTH-1:0];
        ADDR_OUTCLEAR:  if (SetClrEn) data_d = data_q & ~writedata[WIDTH-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata_d = '0;
    case (address)
      ADDR_DATA:      rdata_d[WIDTH-1:0] = data_q;
      ADDR_PULSE_LEN: rdata_d[CNT_W-1:0] = len_q;
      ADDR_PULSE:     rdata_d[WIDTH-1:0] = mask;
      ADDR_STATUS: begin
        rdata_d[STATUS_BUSY_BIT]                = busy;
        rdata_d[STATUS_COUNT_LSB +: CNT_W]      = count;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= RESET_VAL;
      len_q   <= '0;
      rdata_q <= '0;
    end else begin
      data_q  <= data_d;
      len_q   <= len_d;
      rdata_q <= rdata_d;
    end
  end

  aula_pio_pulse_timer #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (pulse_load),
    .load_mask(writedata[WIDTH-1:0]),
    .len      (len_q),
    .mask     (mask),
    .busy     (busy),
    .count    (count)
  );

  assign readdata = rdata_q;
  assign out_port = data_q | mask;

endmodule

// File: tb/tb_aula_20201105_qsys_led_oc.sv
// Bench for the LED output PIO: cycle-level model with absolute pulse end times plus
// directed scenarios with literal expectations.
module tb_aula_20201105_qsys_led_oc;

  localparam logic [7:0] RV = 8'h81;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int n_chk = 0;
  int n_pass = 0;
  bit run = 1'b0;

  aula_20201105_qsys_led_oc #(
    .WIDTH(8),
    .CNT_W(16),
    .RESET_VAL(RV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  always #5 clk = ~clk;

  // Model: a pulse is a mask plus the absolute edge number at which it ends.
  longint     cyc = 0;
  longint     m_end = 0;
  logic [7:0] m_data = RV;
  logic [15:0] m_len = 16'd0;
  logic [7:0] m_mask = 8'd0;
  logic [31:0] m_rd = 32'd0;

  function automatic longint rem();
    return (m_end > cyc) ? (m_end - cyc) : 64'd0;
  endfunction

  function automatic logic [7:0] model_out();
    return m_data | ((rem() != 0) ? m_mask : 8'd0);
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    longint r;
    r = rem();
    case (a)
      3'd0: return {24'd0, m_data};
      3'd1: return {16'd0, m_len};
      3'd2: return {24'd0, (r != 0) ? m_mask : 8'd0};
      3'd3: return {r[15:0], 15'd0, (r != 0)};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc <= 0; m_end <= 0; m_data <= RV; m_len <= 16'd0; m_mask <= 8'd0; m_rd <= 32'd0;
    end else begin
      cyc  <= cyc + 1;
      m_rd <= model_read(address);
      if (chipselect && !write_n) begin
        if (address == 3'd0) m_data <= writedata[7:0];
        if (address == 3'd1) m_len <= writedata[15:0];
        if (address == 3'd2 && writedata[7:0] != 8'd0 && m_len != 16'd0) begin
          m_mask <= writedata[7:0];
          m_end  <= cyc + 1 + longint'(m_len);
        end
`ifdef LED_OC_BITSETCLR_EN
        if (address == 3'd4) m_data <= m_data | writedata[7:0];
        if (address == 3'd5) m_data <= m_data & ~writedata[7:0];
`endif
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (run) begin
      check("model_readdata", readdata, m_rd);
      check("model_out_port", {24'd0, out_port}, {24'd0, model_out()});
    end
  end

  // One bus cycle: inputs applied now, sampled at the next edge; returns 1 time unit after it.
  task automatic cycle(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] d);
    address = a; chipselect = cs; write_n = wn; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cycle(a, 1'b1, 1'b0, d);
  endtask

  task automatic rd(input logic [2:0] a);
    cycle(a, 1'b0, 1'b1, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(address, 1'b0, 1'b1, 32'd0);
  endtask

  logic [7:0] exp_out3 [4] = '{8'h0F, 8'h0F, 8'h0F, 8'h00};
  logic       exp_busy3 [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_port", {24'd0, out_port}, {24'd0, RV});
    check("reset_readdata", readdata, 32'd0);
    reset = 1'b0;
    run = 1'b1;

    // 1: async reset in the middle of a pulse with count 5
    wr(3'd1, 32'd8);
    wr(3'd2, 32'h3C);
    idle(3);
    rd(3'd3);
    check("t1_status_before", readdata, {16'd5, 15'd0, 1'b1});
    #2 reset = 1'b1;
    #1;
    check("t1_out_in_reset", {24'd0, out_port}, {24'd0, RV});
    check("t1_rd_in_reset", readdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    rd(3'd3);
    check("t1_status_after", readdata, 32'd0);

    // 2: DATA write and readback, same-cycle read returns old value
    wr(3'd0, 32'hA5);
    rd(3'd0);
    check("t2_read_data", readdata, 32'h0000_00A5);
    check("t2_out_port", {24'd0, out_port}, 32'hA5);
    cycle(3'd0, 1'b1, 1'b0, 32'h33);
    check("t2_old_on_write", readdata, 32'h0000_00A5);
    rd(3'd0);
    check("t2_new_data", readdata, 32'h33);

    // 3: three-cycle pulse of 0x0F over DATA=0
    wr(3'd1, 32'd3);
    wr(3'd0, 32'd0);
    wr(3'd2, 32'h0F);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_out_%0d", i), {24'd0, out_port}, {24'd0, exp_out3[i]});
      rd(3'd3);
      check($sformatf("t3_busy_%0d", i), {31'd0, readdata[0]}, {31'd0, exp_busy3[i]});
    end

    // 4: retrigger at count 1 replaces the mask and reloads the count
    wr(3'd1, 32'd10);
    wr(3'd2, 32'h01);
    idle(9);
    check("t4_last_tick", {24'd0, out_port}, 32'h01);
    wr(3'd2, 32'h80);
    check("t4_retrig", {24'd0, out_port}, 32'h80);
    idle(9);
    check("t4_still_high", {24'd0, out_port}, 32'h80);
    idle(1);
    check("t4_ended", {24'd0, out_port}, 32'h00);

    // Pulse overlapping DATA leaves the DATA bit high afterwards
    wr(3'd0, 32'h01);
    wr(3'd1, 32'd2);
    wr(3'd2, 32'h03);
    check("ovl_high", {24'd0, out_port}, 32'h03);
    idle(2);
    check("ovl_end", {24'd0, out_port}, 32'h01);

    // 5: zero-length pulse ignored, unmapped address ignored
    wr(3'd0, 32'h5A);
    wr(3'd1, 32'd0);
    wr(3'd2, 32'hFF);
    check("t5_out", {24'd0, out_port}, 32'h5A);
    rd(3'd3);
    check("t5_status", readdata, 32'd0);
    wr(3'd6, 32'hFFFF_FFFF);
    rd(3'd0);
    check("t5_data_kept", readdata, 32'h5A);
    rd(3'd1);
    check("t5_len_kept", readdata, 32'd0);
    rd(3'd6);
    check("t5_unmapped_rd", readdata, 32'd0);

    // 6: bit set/clear registers
    wr(3'd0, 32'h0F);
    wr(3'd4, 32'hF0);
    wr(3'd5, 32'h03);
    rd(3'd0);
`ifdef LED_OC_BITSETCLR_EN
    check("t6_setclr", readdata, 32'hFC);
`else
    check("t6_unmapped", readdata, 32'h0F);
`endif
    rd(3'd4);
    check("t6_rd4", readdata, 32'd0);
    idle(2);

    run = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
